// File: rtl/mux_fault_pattern_tx.sv
// Fault-pattern transmitter: walks all 8 inputs of a gate-level 2:1 mux model with an optional
// stuck-at fault and streams {inputs, 9 observed wires} records over valid/ready.
module mux_fault_pattern_tx #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fault_en,
    input  logic [3:0] fault_wire,
    input  logic       fault_val,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] tx_vec,
    output logic [8:0] tx_out,
    output logic       tx_last,
    output logic       busy,
    output logic       done,
    output logic       err_cfg
);

    localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);

    typedef enum logic [1:0] {StIdle, StApply, StSend, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      p_q, p_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_d;
    logic            cfg_load;
    logic            fen_q;
    logic [3:0]      fwire_q;
    logic            fval_q;
    logic [8:0]      fmask;
    logic [8:0]      wires;

    // Wire index fwire_q is only ever legal (0..8) once latched, so the shift stays in range.
    always_comb begin
        fmask = '0;
        if (fen_q) begin
            fmask = 9'b1 << fwire_q;
        end
    end

    // Each wire is forced before it feeds anything downstream.
    always_comb begin
        wires    = '0;
        wires[0] = fmask[0] ? fval_q : p_q[2];
        wires[1] = fmask[1] ? fval_q : p_q[1];
        wires[2] = fmask[2] ? fval_q : p_q[0];
        wires[3] = fmask[3] ? fval_q : wires[2];
        wires[4] = fmask[4] ? fval_q : wires[2];
        wires[5] = fmask[5] ? fval_q : ~wires[4];
        wires[6] = fmask[6] ? fval_q : (wires[1] & wires[3]);
        wires[7] = fmask[7] ? fval_q : (wires[0] & wires[5]);
        wires[8] = fmask[8] ? fval_q : (wires[6] | wires[7]);
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        err_d    = err_cfg;
        cfg_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (fault_en && (fault_wire > 4'd8)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        cfg_load = 1'b1;
                        p_d      = '0;
                        cnt_d    = '0;
                        state_d  = StApply;
                    end
                end
            end
            StApply: begin
                if (cnt_q == SettleCnt) begin
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (p_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        p_d     = p_q + 3'd1;
                        cnt_d   = '0;
                        state_d = StApply;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            p_q      <= '0;
            cnt_q    <= '0;
            fen_q    <= 1'b0;
            fwire_q  <= '0;
            fval_q   <= 1'b0;
            tx_valid <= 1'b0;
            tx_vec   <= '0;
            tx_out   <= '0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_cfg  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            err_cfg  <= err_d;
            tx_valid <= (state_d == StSend);
            busy     <= (state_d != StIdle);
            done     <= (state_d == StDone);
            if (cfg_load) begin
                fen_q   <= fault_en;
                fwire_q <= fault_wire;
                fval_q  <= fault_val;
            end
            // The record is captured once, on entry to SEND, and held through backpressure.
            if ((state_q == StApply) && (state_d == StSend)) begin
                tx_vec  <= p_q;
                tx_out  <= wires;
                tx_last <= (p_q == 3'd7);
            end
        end
    end

endmodule

// File: tb/tb_mux_fault_pattern_tx.sv
// Bench for mux_fault_pattern_tx: cycle-level behavioural model with per-cycle compare,
// plus literal record and timing expectations for the directed runs.
module tb_mux_fault_pattern_tx;

    localparam int unsigned SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       fault_en = 1'b0;
    logic [3:0] fault_wire = 4'd0;
    logic       fault_val = 1'b0;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [2:0] tx_vec;
    logic [8:0] tx_out;
    logic       tx_last;
    logic       busy;
    logic       done;
    logic       err_cfg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_fault_pattern_tx #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fault_en  (fault_en),
        .fault_wire(fault_wire),
        .fault_val (fault_val),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_vec    (tx_vec),
        .tx_out    (tx_out),
        .tx_last   (tx_last),
        .busy      (busy),
        .done      (done),
        .err_cfg   (err_cfg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Evaluate the mux netlist wire by wire in topological order, forcing the faulted wire.
    function automatic logic [8:0] mux_wires(input logic [2:0] p, input logic en,
                                             input logic [3:0] fw, input logic fv);
        logic [8:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       w[i] = p[2];
                1:       w[i] = p[1];
                2:       w[i] = p[0];
                3:       w[i] = w[2];
                4:       w[i] = w[2];
                5:       w[i] = ~w[4];
                6:       w[i] = w[1] & w[3];
                7:       w[i] = w[0] & w[5];
                default: w[i] = w[6] | w[7];
            endcase
            if (en && (fw == 4'(i))) w[i] = fv;
        end
        return w;
    endfunction

    // Behavioural model
    bit         m_busy = 0, m_valid = 0, m_done = 0, m_err = 0, m_after_rst = 0;
    int         m_wait = 0;
    logic [2:0] m_p = '0;
    logic       cf_en = 0, cf_val = 0;
    logic [3:0] cf_wire = '0;
    int         cyc = 0, start_cyc = 0, done_cyc = 0;
    int         acc_cyc[8];
    logic [8:0] cap[8];
    bit         chk_en = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        m_after_rst <= rst;
        if (done) done_cyc <= cyc;
        if (tx_valid && tx_ready) begin
            acc_cyc[tx_vec] <= cyc;
            cap[tx_vec]     <= tx_out;
        end
        if (rst) begin
            m_busy  <= 0;
            m_valid <= 0;
            m_done  <= 0;
            m_err   <= 0;
            m_wait  <= 0;
            m_p     <= '0;
        end else begin
            m_done <= 0;
            if (m_done) m_busy <= 0;
            if (!m_busy) begin
                if (start) begin
                    if (fault_en && fault_wire > 4'd8) begin
                        m_err <= 1;
                    end else begin
                        m_err     <= 0;
                        m_busy    <= 1;
                        m_p       <= '0;
                        m_wait    <= int'(SETTLE);
                        cf_en     <= fault_en;
                        cf_wire   <= fault_wire;
                        cf_val    <= fault_val;
                        start_cyc <= cyc;
                    end
                end
            end else if (m_valid) begin
                if (tx_ready) begin
                    m_valid <= 0;
                    if (m_p == 3'd7) begin
                        m_done <= 1;
                    end else begin
                        m_p    <= m_p + 3'd1;
                        m_wait <= int'(SETTLE);
                    end
                end
            end else if (!m_done) begin
                if (m_wait == 0) m_valid <= 1;
                else m_wait <= m_wait - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("tx_valid", 32'(tx_valid), 32'(m_valid));
            chk("done", 32'(done), 32'(m_done));
            chk("err_cfg", 32'(err_cfg), 32'(m_err));
            if (m_valid) begin
                chk("tx_vec", 32'(tx_vec), 32'(m_p));
                chk("tx_out", 32'(tx_out), 32'(mux_wires(m_p, cf_en, cf_wire, cf_val)));
                chk("tx_last", 32'(tx_last), 32'(m_p == 3'd7));
            end
            if (m_after_rst) chk("reset_record", 32'({tx_last, tx_vec, tx_out}), 32'd0);
        end
    end

    task automatic do_start(input logic en, input logic [3:0] w, input logic v);
        @(negedge clk);
        fault_en   = en;
        fault_wire = w;
        fault_val  = v;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_vec(input logic [2:0] v, input string tag);
        bit seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid && tx_vec == v) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0;

        // Model self-pins
        chk("model_p6", 32'(mux_wires(3'd6, 0, 4'd0, 0)), 32'(9'b110100011));
        chk("model_p5_ff", 32'(mux_wires(3'd5, 0, 4'd0, 0)), 32'(9'b000011101));

        // Fault-free run
        do_start(1'b0, 4'd0, 1'b0);
        wait_done("run1_timeout");
        chk("run1_p6", 32'(cap[6]), 32'(9'b110100011));
        chk("run1_p3", 32'(cap[3]), 32'(9'b101011110));
        chk("run1_acc0", 32'(acc_cyc[0] - start_cyc), 32'd4);
        chk("run1_acc7", 32'(acc_cyc[7] - start_cyc), 32'd32);
        chk("run1_done", 32'(done_cyc - start_cyc), 32'd33);

        // Wire 2 stuck-at-0
        do_start(1'b1, 4'd2, 1'b0);
        wait_done("run2_timeout");
        chk("run2_p3", 32'(cap[3]), 32'(9'b000100010));
        chk("run2_p0", 32'(cap[0]), 32'(9'b000100000));

        // Wire 5 stuck-at-1
        do_start(1'b1, 4'd5, 1'b1);
        wait_done("run3_timeout");
        chk("run3_v101", 32'(cap[5]), 32'(9'b110111101));

        // Backpressure during record 2
        do_start(1'b0, 4'd0, 1'b0);
        wait_vec(3'd2, "bp_wait_timeout");
        tx_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_hold_vec", 32'(tx_vec), 32'd2);
        tx_ready = 1'b1;
        wait_done("run4_timeout");

        // Illegal configuration, then a legal run clears the error
        do_start(1'b1, 4'd9, 1'b0);
        repeat (2) @(negedge clk);
        chk("err_set", 32'(err_cfg), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        do_start(1'b0, 4'd0, 1'b0);
        chk("err_clr", 32'(err_cfg), 32'd0);
        wait_done("run5_timeout");

        // Reset during SEND of p=4
        do_start(1'b1, 4'd7, 1'b0);
        wait_vec(3'd4, "rst_wait_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Restart, with an ignored start pulse mid-run
        do_start(1'b0, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        fault_en   = 1'b1;
        fault_wire = 4'd9;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        fault_en   = 1'b0;
        fault_wire = 4'd0;
        wait_done("run6_timeout");
        chk("run6_p0", 32'(cap[0]), 32'(9'b000100000));
        chk("run6_err", 32'(err_cfg), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
